// File: rtl/mpu_bus_sequencer.sv
// mpu_bus_sequencer
//   Drives the external 6502: generates its phase-2 clock (free-run or single
//   step), runs the MPU reset sequence, owns BE, and answers every read with
//   the reset vector at $FFFC/$FFFD or a fixed opcode elsewhere so the MPU can
//   run with no memory attached.
//
// Ports
//   clk          in   1   system clock
//   rst          in   1   synchronous active-high reset
//   run_en       in   1   level, 1 = free-run MPU clock
//   step_press   in   1   pulse, advances one MPU cycle while stopped
//   mpu_rst_req  in   1   pulse, restarts the MPU reset sequence
//   addr_bus     in   16  MPU address bus
//   mpu_clk      out  1   MPU phase-2 clock
//   mpu_rst_n    out  1   MPU RESB, active low
//   bus_en       out  1   MPU BE
//   data_bus     out  8   byte presented to the MPU
//   cycle_cnt    out  16  completed MPU cycles since the last reset sequence
//   stopped      out  1   clock parked high waiting for run/step
module mpu_bus_sequencer #(
  parameter int unsigned DIV        = 25,
  parameter int unsigned RST_CYCLES = 8,
  parameter logic [15:0] RESET_VEC  = 16'h0200,
  parameter logic [7:0]  FILL_OP    = 8'hEA
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run_en,
  input  logic        step_press,
  input  logic        mpu_rst_req,
  input  logic [15:0] addr_bus,
  output logic        mpu_clk,
  output logic        mpu_rst_n,
  output logic        bus_en,
  output logic [7:0]  data_bus,
  output logic [15:0] cycle_cnt,
  output logic        stopped
);

  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [PW-1:0] PHASE_LAST = PW'(DIV - 1);
  localparam logic [RW-1:0] RST_LAST   = RW'(RST_CYCLES - 1);

  typedef enum logic [2:0] {
    S_RST_LO,
    S_RST_HI,
    S_STOP,
    S_LO,
    S_HI
  } state_t;

  state_t        state_q, state_nxt;
  logic [PW-1:0] phase_q, phase_nxt;
  logic [RW-1:0] rcnt_q, rcnt_nxt;
  logic [15:0]   cnt_nxt;
  logic [7:0]    data_nxt;
  logic          phase_end;

  assign phase_end = (phase_q == PHASE_LAST);

  always_comb begin
    state_nxt = state_q;
    phase_nxt = phase_q;
    rcnt_nxt  = rcnt_q;
    cnt_nxt   = cycle_cnt;

    unique case (state_q)
      S_RST_LO: begin
        if (phase_end) begin
          state_nxt = S_RST_HI;
          phase_nxt = '0;
        end else begin
          phase_nxt = phase_q + PW'(1);
        end
      end
      S_RST_HI: begin
        if (phase_end) begin
          phase_nxt = '0;
          if (rcnt_q == RST_LAST) begin
            state_nxt = S_STOP;
            rcnt_nxt  = '0;
          end else begin
            state_nxt = S_RST_LO;
            rcnt_nxt  = rcnt_q + RW'(1);
          end
        end else begin
          phase_nxt = phase_q + PW'(1);
        end
      end
      S_STOP: begin
        if (run_en || step_press) begin
          state_nxt = S_LO;
          phase_nxt = '0;
        end
      end
      S_LO: begin
        if (phase_end) begin
          state_nxt = S_HI;
          phase_nxt = '0;
        end else begin
          phase_nxt = phase_q + PW'(1);
        end
      end
      S_HI: begin
        if (phase_end) begin
          phase_nxt = '0;
          cnt_nxt   = cycle_cnt + 16'd1;
          state_nxt = run_en ? S_LO : S_STOP;
        end else begin
          phase_nxt = phase_q + PW'(1);
        end
      end
      default: begin
        state_nxt = S_RST_LO;
        phase_nxt = '0;
        rcnt_nxt  = '0;
      end
    endcase

    if (mpu_rst_req) begin
      state_nxt = S_RST_LO;
      phase_nxt = '0;
      rcnt_nxt  = '0;
      cnt_nxt   = '0;
    end

    unique case (addr_bus)
      16'hFFFC: data_nxt = RESET_VEC[7:0];
      16'hFFFD: data_nxt = RESET_VEC[15:8];
      default:  data_nxt = FILL_OP;
    endcase
  end

  // Pin outputs are registered from the next state so they change on the same
  // clk as the state they belong to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_RST_LO;
      phase_q   <= '0;
      rcnt_q    <= '0;
      cycle_cnt <= '0;
      mpu_clk   <= 1'b0;
      mpu_rst_n <= 1'b0;
      bus_en    <= 1'b0;
      stopped   <= 1'b0;
      data_bus  <= FILL_OP;
    end else begin
      state_q   <= state_nxt;
      phase_q   <= phase_nxt;
      rcnt_q    <= rcnt_nxt;
      cycle_cnt <= cnt_nxt;
      mpu_clk   <= (state_nxt == S_RST_HI) || (state_nxt == S_HI) || (state_nxt == S_STOP);
      mpu_rst_n <= (state_nxt != S_RST_LO) && (state_nxt != S_RST_HI);
      bus_en    <= (state_nxt != S_RST_LO) && (state_nxt != S_RST_HI);
      stopped   <= (state_nxt == S_STOP);
      data_bus  <= data_nxt;
    end
  end

endmodule

// File: tb/tb_mpu_bus_sequencer.sv
// tb_mpu_bus_sequencer
//   Drives mpu_bus_sequencer with directed and random stimulus and compares
//   every output each clk against a reference model that tracks the MPU as
//   "elapsed clks in reset" or "position inside the current MPU cycle".
module tb_mpu_bus_sequencer;

  localparam int unsigned DIV        = 2;
  localparam int unsigned RST_CYCLES = 2;
  localparam logic [15:0] RESET_VEC  = 16'h1234;
  localparam logic [7:0]  FILL_OP    = 8'hEA;

  localparam int M_RESET = 0;
  localparam int M_STOP  = 1;
  localparam int M_RUN   = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        run_en = 1'b0;
  logic        step_press = 1'b0;
  logic        mpu_rst_req = 1'b0;
  logic [15:0] addr_bus = 16'h0000;
  logic        mpu_clk;
  logic        mpu_rst_n;
  logic        bus_en;
  logic [7:0]  data_bus;
  logic [15:0] cycle_cnt;
  logic        stopped;

  int n_checks = 0;
  int n_errors = 0;

  // reference model
  int          m_mode = M_RESET;
  int          m_t    = 0;   // clks elapsed since reset sequence began
  int          m_pos  = 0;   // clks elapsed in the current MPU cycle
  int          m_cnt  = 0;
  logic [7:0]  m_data = FILL_OP;

  mpu_bus_sequencer #(
    .DIV(DIV),
    .RST_CYCLES(RST_CYCLES),
    .RESET_VEC(RESET_VEC),
    .FILL_OP(FILL_OP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .run_en(run_en),
    .step_press(step_press),
    .mpu_rst_req(mpu_rst_req),
    .addr_bus(addr_bus),
    .mpu_clk(mpu_clk),
    .mpu_rst_n(mpu_rst_n),
    .bus_en(bus_en),
    .data_bus(data_bus),
    .cycle_cnt(cycle_cnt),
    .stopped(stopped)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] decode(input logic [15:0] a);
    if (a == 16'hFFFC) return RESET_VEC[7:0];
    if (a == 16'hFFFD) return RESET_VEC[15:8];
    return FILL_OP;
  endfunction

  task automatic model_step();
    m_data = rst ? FILL_OP : decode(addr_bus);
    if (rst || mpu_rst_req) begin
      m_mode = M_RESET;
      m_t    = 0;
      m_cnt  = 0;
    end else if (m_mode == M_RESET) begin
      m_t++;
      if (m_t == 2 * DIV * RST_CYCLES) m_mode = M_STOP;
    end else if (m_mode == M_STOP) begin
      if (run_en || step_press) begin
        m_mode = M_RUN;
        m_pos  = 0;
      end
    end else begin
      m_pos++;
      if (m_pos == 2 * DIV) begin
        m_cnt = (m_cnt + 1) % 65536;
        m_pos = 0;
        if (!run_en) m_mode = M_STOP;
      end
    end
  endtask

  task automatic check_all();
    logic exp_clk;
    if (m_mode == M_RESET)     exp_clk = ((m_t / DIV) % 2) == 1;
    else if (m_mode == M_STOP) exp_clk = 1'b1;
    else                       exp_clk = (m_pos >= DIV);
    check("mpu_clk",   32'(mpu_clk),   32'(exp_clk));
    check("mpu_rst_n", 32'(mpu_rst_n), 32'(m_mode != M_RESET));
    check("bus_en",    32'(bus_en),    32'(m_mode != M_RESET));
    check("stopped",   32'(stopped),   32'(m_mode == M_STOP));
    check("cycle_cnt", 32'(cycle_cnt), 32'(m_cnt));
    check("data_bus",  32'(data_bus),  32'(m_data));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic wait_stopped(input string tag);
    int i = 0;
    while (m_mode != M_STOP && i < 200) begin
      tick();
      i++;
    end
    check(tag, 32'(stopped), 32'd1);
  endtask

  task automatic pulse_step();
    step_press = 1'b1;
    tick();
    step_press = 1'b0;
  endtask

  initial begin
    // 1: reset and reset sequence
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mpu_clk", 32'(mpu_clk), 32'd0);
    check("rst_data", 32'(data_bus), 32'(FILL_OP));
    repeat (2 * DIV * RST_CYCLES) tick();
    check("rstseq_done_clk", 32'(mpu_clk), 32'd1);
    check("rstseq_done_rst_n", 32'(mpu_rst_n), 32'd1);
    check("rstseq_done_stopped", 32'(stopped), 32'd1);
    check("rstseq_done_cnt", 32'(cycle_cnt), 32'd0);

    // 2: single step, second pulse while running is dropped
    pulse_step();
    check("step_lo", 32'(mpu_clk), 32'd0);
    pulse_step();
    wait_stopped("step_stop");
    check("step_cnt", 32'(cycle_cnt), 32'd1);
    check("step_park_hi", 32'(mpu_clk), 32'd1);

    // 3: free run, then drop run_en in the low phase
    run_en = 1'b1;
    repeat (12) tick();
    check("run12_cnt", 32'(cycle_cnt), 32'd3);
    for (int i = 0; i < 20 && !(m_mode == M_RUN && m_pos < DIV); i++) tick();
    run_en = 1'b0;
    wait_stopped("run_drop_stop");
    check("run_drop_clk", 32'(mpu_clk), 32'd1);

    // 4: vector decode
    addr_bus = 16'hFFFC; tick(); check("vec_lo", 32'(data_bus), 32'h34);
    addr_bus = 16'hFFFD; tick(); check("vec_hi", 32'(data_bus), 32'h12);
    addr_bus = 16'h1234; tick(); check("vec_fill", 32'(data_bus), 32'hEA);

    // 5: reset request in the high phase with cnt=5
    run_en = 1'b1;
    for (int i = 0; i < 200 && !(m_cnt == 5 && m_mode == M_RUN && m_pos >= DIV); i++) tick();
    check("reach_cnt5", 32'(cycle_cnt), 32'd5);
    mpu_rst_req = 1'b1;
    tick();
    mpu_rst_req = 1'b0;
    run_en = 1'b0;
    check("req_rst_n", 32'(mpu_rst_n), 32'd0);
    check("req_bus_en", 32'(bus_en), 32'd0);
    check("req_cnt", 32'(cycle_cnt), 32'd0);
    addr_bus = 16'hFFFD; tick(); check("vec_hi_in_rst", 32'(data_bus), 32'h12);
    addr_bus = 16'hFFFC; tick(); check("vec_lo_in_rst", 32'(data_bus), 32'h34);
    wait_stopped("req_rerun_stop");

    // 6: counter wrap
    force dut.cycle_cnt = 16'hFFFF;
    m_cnt = 16'hFFFF;
    tick();
    tick();
    release dut.cycle_cnt;
    tick();
    check("wrap_pre", 32'(cycle_cnt), 32'hFFFF);
    pulse_step();
    wait_stopped("wrap_stop");
    check("wrap_cnt", 32'(cycle_cnt), 32'd0);

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) run_en = ~run_en;
      step_press  = ($urandom_range(0, 9) == 0);
      mpu_rst_req = ($urandom_range(0, 199) == 0);
      rst         = ($urandom_range(0, 499) == 0);
      case ($urandom_range(0, 3))
        0:       addr_bus = 16'hFFFC;
        1:       addr_bus = 16'hFFFD;
        default: addr_bus = 16'($urandom);
      endcase
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
